// File: rtl/imm_pack_pkg.sv
// imm_pack shared types: format codes, legal immediate ranges
// per format, and the payload carried through both stages.
package imm_pack_pkg;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  localparam logic signed [31:0] IS_MIN = -32'sd2048;
  localparam logic signed [31:0] IS_MAX = 32'sd2047;
  localparam logic signed [31:0] B_MIN  = -32'sd4096;
  localparam logic signed [31:0] B_MAX  = 32'sd4094;
  localparam logic signed [31:0] J_MIN  = -32'sd1048576;
  localparam logic signed [31:0] J_MAX  = 32'sd1048574;

  typedef struct packed {
    logic [31:0] instr;
    logic        err;
  } stage_t;

endpackage

// File: rtl/imm_pack_scatter.sv
// imm_scatter: places a signed immediate into RV32 I/S/B/J bit
// positions and flags out-of-range or odd B/J offsets.
module imm_scatter
  import imm_pack_pkg::*;
(
  input  logic [1:0]  imm_src,
  input  logic [31:0] imm,
  input  logic [6:0]  opcode,
  input  logic [4:0]  rd,
  input  logic [2:0]  funct3,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  output stage_t      pay
);

  logic signed [31:0] simm;
  assign simm = imm;

  always_comb begin
    pay = '0;
    unique case (1'b1)
      (imm_src == IMM_I): begin
        pay.instr = {imm[11:0], rs1, funct3,
                     rd, opcode};
        pay.err = (simm < IS_MIN) | (simm > IS_MAX);
      end
      (imm_src == IMM_S): begin
        pay.instr = {imm[11:5], rs2, rs1, funct3,
                     imm[4:0], opcode};
        pay.err = (simm < IS_MIN) | (simm > IS_MAX);
      end
      (imm_src == IMM_B): begin
        pay.instr = {imm[12], imm[10:5], rs2, rs1,
                     funct3, imm[4:1], imm[11],
                     opcode};
        pay.err = (simm < B_MIN) | (simm > B_MAX)
                | imm[0];
      end
      (imm_src == IMM_J): begin
        pay.instr = {imm[20], imm[10:1], imm[11],
                     imm[19:12], rd, opcode};
        pay.err = (simm < J_MIN) | (simm > J_MAX)
                | imm[0];
      end
      default: pay = '0;
    endcase
  end

endmodule

// File: rtl/imm_pack.sv
// imm_pack: two-stage valid/ready instruction packer with a
// saturating count of emitted error beats.
module imm_pack
  import imm_pack_pkg::*;
(
  input  logic        clk,
  input  logic        rstn,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [1:0]  in_imm_src,
  input  logic [31:0] in_imm,
  input  logic [6:0]  in_opcode,
  input  logic [4:0]  in_rd,
  input  logic [2:0]  in_funct3,
  input  logic [4:0]  in_rs1,
  input  logic [4:0]  in_rs2,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic        out_err,
  output logic [15:0] err_count
);

  stage_t pay;
  stage_t s1_q;
  stage_t s2_q;
  logic   s1_valid;
  logic   s2_valid;
  logic   s1_en;
  logic   s2_en;

  imm_scatter u_scatter (
    .imm_src (in_imm_src),
    .imm     (in_imm),
    .opcode  (in_opcode),
    .rd      (in_rd),
    .funct3  (in_funct3),
    .rs1     (in_rs1),
    .rs2     (in_rs2),
    .pay     (pay)
  );

  // A stage may load when it is empty or its
  // contents move on this cycle.
  assign s2_en    = !s2_valid | out_ready;
  assign s1_en    = !s1_valid | s2_en;
  assign in_ready = s1_en;

  assign out_valid = s2_valid;
  assign out_instr = s2_q.instr;
  assign out_err   = s2_q.err;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      s1_valid  <= 1'b0;
      s2_valid  <= 1'b0;
      s1_q      <= '0;
      s2_q      <= '0;
      err_count <= '0;
    end else begin
      if (s1_en) begin
        s1_valid <= in_valid;
        if (in_valid) s1_q <= pay;
      end
      if (s2_en) begin
        s2_valid <= s1_valid;
        if (s1_valid) s2_q <= s1_q;
      end
      if (s2_valid && out_ready && s2_q.err
          && err_count != 16'hFFFF)
        err_count <= err_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_imm_pack.sv
// tb_imm_pack: directed and backpressure checks of imm_pack with
// a scoreboard, round-trip decode and saturation/reset checks.
module tb_imm_pack;

  logic        clk = 1'b0;
  logic        rstn;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_imm_src;
  logic [31:0] in_imm;
  logic [6:0]  in_opcode;
  logic [4:0]  in_rd;
  logic [2:0]  in_funct3;
  logic [4:0]  in_rs1;
  logic [4:0]  in_rs2;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic        out_err;
  logic [15:0] err_count;

  always #5 clk = ~clk;

  imm_pack dut (
    .clk        (clk),
    .rstn       (rstn),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_imm_src (in_imm_src),
    .in_imm     (in_imm),
    .in_opcode  (in_opcode),
    .in_rd      (in_rd),
    .in_funct3  (in_funct3),
    .in_rs1     (in_rs1),
    .in_rs2     (in_rs2),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_instr  (out_instr),
    .out_err    (out_err),
    .err_count  (err_count)
  );

  typedef struct {
    logic [1:0]  fmt;
    logic [31:0] imm;
    logic [6:0]  op;
    logic [4:0]  rd;
    logic [2:0]  f3;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        known;
    logic [31:0] instr;
    logic        err;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   exp_errs = 0;
  logic mon_en = 1'b0;
  logic stall_prev = 1'b0;
  logic [31:0] hold_i;
  logic hold_e;
  logic rdone;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] dec(input logic [1:0] f,
                                      input logic [31:0] i);
    case (f)
      2'b00: dec = {{20{i[31]}}, i[31:20]};
      2'b01: dec = {{20{i[31]}}, i[31:25], i[11:7]};
      2'b10: dec = {{19{i[31]}}, i[31], i[7], i[30:25],
                    i[11:8], 1'b0};
      default: dec = {{11{i[31]}}, i[31], i[19:12], i[20],
                      i[30:21], 1'b0};
    endcase
  endfunction

  function automatic logic exp_err(input logic [1:0] f,
                                   input logic [31:0] imm);
    int signed s;
    s = imm;
    case (f)
      2'b00, 2'b01: exp_err = (s < -2048) || (s > 2047);
      2'b10: exp_err = (s < -4096) || (s > 4094) || imm[0];
      default: exp_err = (s < -1048576) || (s > 1048574)
                         || imm[0];
    endcase
  endfunction

  function automatic exp_t mk(
    input logic [1:0] f, input logic [31:0] imm,
    input logic [6:0] op, input logic [4:0] rd,
    input logic [2:0] f3, input logic [4:0] rs1,
    input logic [4:0] rs2, input logic known,
    input logic [31:0] instr, input logic err);
    mk.fmt = f; mk.imm = imm; mk.op = op; mk.rd = rd;
    mk.f3 = f3; mk.rs1 = rs1; mk.rs2 = rs2;
    mk.known = known; mk.instr = instr; mk.err = err;
  endfunction

  always @(negedge clk) begin
    if (mon_en && rstn) begin
      if (stall_prev) begin
        chk("hold_v", 32'(out_valid), 32'd1);
        chk("hold_i", out_instr, hold_i);
        chk("hold_e", 32'(out_err), 32'(hold_e));
      end
      stall_prev = out_valid && !out_ready;
      hold_i = out_instr;
      hold_e = out_err;
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          chk("extra", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = q.pop_front();
          if (e.known) chk("instr", out_instr, e.instr);
          chk("err", 32'(out_err), 32'(e.err));
          chk("op", 32'(out_instr[6:0]), 32'(e.op));
          if (e.fmt == 2'b00 || e.fmt == 2'b11)
            chk("rd", 32'(out_instr[11:7]), 32'(e.rd));
          if (e.fmt != 2'b11)
            chk("rs1f3", 32'(out_instr[19:12]),
                32'({e.rs1, e.f3}));
          if (e.fmt == 2'b01 || e.fmt == 2'b10)
            chk("rs2", 32'(out_instr[24:20]), 32'(e.rs2));
          if (!e.err)
            chk("rtrip", dec(e.fmt, out_instr), e.imm);
        end
      end
    end else begin
      stall_prev = 1'b0;
    end
  end

  task automatic send(input exp_t e);
    logic hs;
    in_imm_src = e.fmt;
    in_imm     = e.imm;
    in_opcode  = e.op;
    in_rd      = e.rd;
    in_funct3  = e.f3;
    in_rs1     = e.rs1;
    in_rs2     = e.rs2;
    in_valid   = 1'b1;
    hs = 1'b0;
    for (int i = 0; i < 100 && !hs; i++) begin
      @(negedge clk);
      hs = in_ready;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    if (!hs) chk("send_to", 32'd0, 32'd1);
    else begin
      q.push_back(e);
      if (e.err) exp_errs++;
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 100 && q.size() != 0; i++) begin
      @(posedge clk);
      #1;
    end
    chk("drain", q.size(), 32'd0);
    @(posedge clk);
    #1;
  endtask

  logic [31:0] imm_tab [10];

  initial begin
    exp_t e;
    imm_tab = '{32'd0, -32'd2048, 32'd2047, 32'd4094,
                -32'd4094, 32'd5, 32'd1048574,
                -32'd1048576, -32'd1, 32'd100000};
    rstn = 1'b0;
    in_valid = 1'b0;
    in_imm_src = '0; in_imm = '0; in_opcode = '0;
    in_rd = '0; in_funct3 = '0; in_rs1 = '0; in_rs2 = '0;
    out_ready = 1'b1;
    rdone = 1'b0;
    repeat (3) @(posedge clk);
    #1 rstn = 1'b1;
    @(negedge clk);
    chk("rst_v", 32'(out_valid), 32'd0);
    chk("rst_i", out_instr, 32'd0);
    chk("rst_e", 32'(out_err), 32'd0);
    chk("rst_cnt", 32'(err_count), 32'd0);
    chk("rst_rdy", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1 mon_en = 1'b1;

    // latency of the first beat
    e = mk(2'b00, -32'd1, 7'h13, 5'd1, 3'd0, 5'd0, 5'd0,
           1'b1, 32'hFFF00093, 1'b0);
    send(e);
    @(negedge clk);
    chk("lat1", 32'(out_valid), 32'd0);
    @(negedge clk);
    chk("lat2", 32'(out_valid), 32'd1);
    drain();

    send(mk(2'b01, 32'd2047, 7'h23, 5'd0, 3'd2, 5'd2, 5'd3,
            1'b1, 32'h7E312FA3, 1'b0));
    send(mk(2'b01, 32'd2048, 7'h23, 5'd0, 3'd2, 5'd2, 5'd3,
            1'b1, 32'h80312023, 1'b1));
    drain();
    chk("cnt1", 32'(err_count), 32'd1);

    send(mk(2'b10, -32'd4096, 7'h63, 5'd0, 3'd0, 5'd0, 5'd0,
            1'b1, 32'h80000063, 1'b0));
    send(mk(2'b10, 32'd6, 7'h63, 5'd0, 3'd0, 5'd0, 5'd0,
            1'b1, 32'h00000363, 1'b0));
    send(mk(2'b10, 32'd3, 7'h63, 5'd0, 3'd0, 5'd0, 5'd0,
            1'b1, 32'h00000163, 1'b1));
    send(mk(2'b11, 32'h000FFFFE, 7'h6F, 5'd0, 3'd0, 5'd0,
            5'd0, 1'b1, 32'h7FFFF06F, 1'b0));
    send(mk(2'b11, 32'h00100000, 7'h6F, 5'd0, 3'd0, 5'd0,
            5'd0, 1'b1, 32'h8000006F, 1'b1));
    drain();
    chk("cnt3", 32'(err_count), 32'd3);

    // backpressure with random beats
    fork
      begin
        for (int n = 0; n < 8; n++) begin
          logic [1:0] f;
          logic [31:0] v;
          f = 2'($urandom_range(0, 3));
          v = imm_tab[$urandom_range(0, 9)];
          send(mk(f, v, 7'($urandom_range(0, 127)),
                  5'($urandom_range(0, 31)),
                  3'($urandom_range(0, 7)),
                  5'($urandom_range(0, 31)),
                  5'($urandom_range(0, 31)),
                  1'b0, 32'd0, exp_err(f, v)));
        end
        rdone = 1'b1;
      end
      begin
        while (!rdone) begin
          @(posedge clk);
          #1;
          out_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    out_ready = 1'b1;
    drain();
    chk("cnt_rnd", 32'(err_count), 32'(exp_errs));

    // saturation
    mon_en = 1'b0;
    in_imm_src = 2'b00;
    in_imm = 32'd4096;
    in_valid = 1'b1;
    repeat (32'h10000 + 8) @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1 chk("sat", 32'(err_count), 32'h0000FFFF);

    // reset with both stages full
    out_ready = 1'b0;
    in_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    chk("full_v", 32'(out_valid), 32'd1);
    chk("full_rdy", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1 rstn = 1'b0;
    @(posedge clk);
    #1;
    chk("mrst_v", 32'(out_valid), 32'd0);
    chk("mrst_cnt", 32'(err_count), 32'd0);
    chk("mrst_i", out_instr, 32'd0);
    chk("mrst_e", 32'(out_err), 32'd0);
    chk("mrst_rdy", 32'(in_ready), 32'd1);
    rstn = 1'b1;
    out_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("nostray", 32'(out_valid), 32'd0);
    chk("nocnt", 32'(err_count), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/imm_pack.md
# imm_pack

Immediate encoder and instruction packer; the inverse of the core's immediate-extension decoder. Accepts an opcode, register fields and a 32-bit signed immediate with an immediate-format select, range- and alignment-checks the immediate, and scatters it into the RV32 I/S/B/J bit positions of a 32-bit instruction word. Sits in the program-loader / self-test path feeding instruction memory. Two registered stages with valid/ready flow control, full throughput, plus a saturating error counter.

## Interface
- No parameters.
- clk  in  1  clock; all state on posedge.
- rstn  in  1  synchronous active-low reset.
- in_valid  in  1  input beat present.
- in_ready  out  1  block accepts beat this cycle.
- in_imm_src  in  2  format select: 00 I, 01 S, 10 B, 11 J.
- in_imm  in  32  signed immediate, byte offset for B/J.
- in_opcode  in  7  placed at instr[6:0].
- in_rd  in  5  instr[11:7]; ignored for S/B.
- in_funct3  in  3  instr[14:12]; ignored for J.
- in_rs1  in  5  instr[19:15]; ignored for J.
- in_rs2  in  5  instr[24:20]; used for S/B only.
- out_valid  out  1  packed word present.
- out_ready  in  1  downstream accepts.
- out_instr  out  32  packed instruction.
- out_err  out  1  immediate out of range or misaligned for its format.
- err_count  out  16  saturating count of beats emitted with out_err=1.

## Operation
- Bit placement (imm = in_imm):
  - I: instr[31:20]=imm[11:0].
  - S: instr[31:25]=imm[11:5], instr[11:7]=imm[4:0].
  - B: instr[31]=imm[12], [30:25]=imm[10:5], [11:8]=imm[4:1], [7]=imm[11].
  - J: instr[31]=imm[20], [30:21]=imm[10:1], [20]=imm[11], [19:12]=imm[19:12].
- Legal ranges: I/S −2048..2047; B −4096..4094 and imm[0]=0; J −1048576..1048574 and imm[0]=0. Range is a signed 32-bit comparison.
- Violation: out_err=1; the word is still packed from the truncated bits shown above. The dropped imm[0] is not reported separately.
- Round-trip invariant: when out_err=0, feeding out_instr[31:7] with the same format select into the immediate-extension decoder returns in_imm exactly.
- err_count increments on each output handshake with out_err=1 and saturates at 0xFFFF.

## Timing
- Stage 1 registers packed word and error flag on input handshake (in_valid & in_ready). Stage 2 is the output register.
- Latency: 2 cycles from input handshake to out_valid when unstalled. Throughput 1 beat/cycle.
- in_ready = !s1_valid | !s2_valid | out_ready (combinational from out_ready permitted).
- Stage 1 advances to stage 2 when stage 2 is empty or handshaking this cycle. Otherwise both stages hold.
- out_valid, out_instr and out_err are stable while out_valid=1 and out_ready=0.
- Simultaneous input and output handshakes in one cycle are legal and lose no beat.
- Reset: s1_valid=0, s2_valid=0, out_valid=0, out_instr=0, out_err=0, err_count=0. in_ready=1 in the first cycle after reset.
- Reset mid-stream discards in-flight beats and does not count them.

## Structure
- Shared package holds:
  - format codes IMM_I=2'b00, IMM_S=2'b01, IMM_B=2'b10, IMM_J=2'b11;
  - signed range limits per format;
  - a packed struct for the stage payload {instr[31:0], err}.
- One combinational sub-module, imm_scatter: performs bit placement plus range/alignment check. The top-level holds the two-stage valid/ready pipeline and err_count.

## Test plan
- I, imm=−1, opcode=0x13, rd=1, funct3=0, rs1=0 → out_instr=0xFFF00093, out_err=0, two cycles after handshake.
- S, imm=2047 (0x7FF), opcode=0x23, funct3=2, rs1=2, rs2=3 → out_instr=0x7E312FA3, err=0. Same with imm=2048 → err=1, err_count=1.
- B, imm=−4096, opcode=0x63, all registers 0 → out_instr=0x80000063, err=0. imm=6 → 0x00000363. imm=3 → err=1.
- J, imm=0x000FFFFE, opcode=0x6F, rd=0 → out_instr=0x7FFFF06F, err=0. imm=0x00100000 → err=1.
- Backpressure: 8 random beats with out_ready toggling pseudo-randomly → all 8 emerge in order, none dropped or duplicated, outputs stable during stall. Round-trip decode matches for every err=0 beat.
- Saturation and reset: force 0x10000 error beats → err_count=0xFFFF. Assert rstn low with both stages full → next cycle out_valid=0 and err_count=0.
